// File: rtl/bus_master_copy_pkg.sv
// Shared definitions for the bus-master block-copy engine:
// FSM state encoding, default bus widths and slave window bases.
package bus_master_copy_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   localparam logic [7:0] RAM_BASE = 8'h00;
   localparam logic [7:0] RAM_TOP  = 8'h1F;
   localparam logic [7:0] ALU_BASE = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_RD   = 3'd2,
      S_RDW  = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } state_t;

endpackage

// File: rtl/bus_master_copy.sv
// Block-copy bus master: reads each word over the bus into a buffer,
// then writes it back to the destination, one word at a time.
module bus_master_copy
   import bus_master_copy_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = 6,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              M_req,
   output logic              M_wr,
   output logic [ADDR_W-1:0] M_addr,
   output logic [DATA_W-1:0] M_dout,
   input  logic              M_grant,
   input  logic [DATA_W-1:0] M_din
);

   state_t            state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx;
   logic [1:0]        lat;
   logic [DATA_W-1:0] data_q;

   logic              last_word;
   logic              lat_end;
   logic [LEN_W-1:0]  idx_nxt;

   assign last_word = (idx == len_q - LEN_W'(1));
   assign lat_end   = (lat == 2'(RD_LAT - 1));
   assign idx_nxt   = idx + LEN_W'(1);
   assign M_dout    = data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         idx    <= '0;
         lat    <= '0;
         data_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         M_req  <= 1'b0;
         M_wr   <= 1'b0;
         M_addr <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     src_q <= src_addr;
                     dst_q <= dst_addr;
                     len_q <= len;
                     idx   <= '0;
                     busy  <= 1'b1;
                     M_req <= 1'b1;
                     state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (M_grant) begin
                  M_wr   <= 1'b0;
                  M_addr <= src_q + ADDR_W'(idx);
                  state  <= S_RD;
               end
            end
            S_RD: begin
               if (M_grant) begin
                  lat   <= '0;
                  state <= S_RDW;
               end
            end
            // read data is taken on the last latency cycle even if grant drops
            S_RDW: begin
               if (lat_end) begin
                  data_q <= M_din;
                  M_wr   <= 1'b1;
                  M_addr <= dst_q + ADDR_W'(idx);
                  state  <= S_WR;
               end else begin
                  lat <= lat + 2'd1;
               end
            end
            S_WR: begin
               if (M_grant) begin
                  M_wr <= 1'b0;
                  if (last_word) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     M_req <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     idx    <= idx_nxt;
                     M_addr <= src_q + ADDR_W'(idx_nxt);
                     state  <= S_RD;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/bus_master_copy.md
Name: bus_master_copy

Overview:
- Bus-master engine that drives the master side of the system bus: M_req, M_wr, M_addr and M_dout out; M_grant and M_din in.
- Performs block copies between slave address ranges. Each word is read over the bus, held in a buffer, then written back over the bus.
- Sits in place of the external master at the top level. It moves data between the RAM slave window and the ALU-with-multiplier slave window without a testbench driving the bus.

Parameters:
- ADDR_W, 8, bus address width (matches M_addr).
- DATA_W, 32, bus data width (matches M_dout/M_din).
- LEN_W, 6, width of transfer length; maximum length is 32 words.
- RD_LAT, 1, cycles from the read-address cycle until M_din is valid. Legal range is 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that launches a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source address, latched on an accepted start.
- dst_addr  in  ADDR_W  first destination address, latched on an accepted start.
- len  in  LEN_W  number of words to copy, latched on an accepted start; values 0..32.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- M_req  out  1  bus request to the arbiter.
- M_wr  out  1  bus write strobe (1 = write, 0 = read).
- M_addr  out  ADDR_W  bus address.
- M_dout  out  DATA_W  write data to the bus.
- M_grant  in  1  bus grant from the arbiter.
- M_din  in  DATA_W  read data from the bus.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (reset_n). On reset, all outputs are 0, state is IDLE, and all counters and buffers are 0.
- Outputs are registered or decoded from state only. There is no combinational path from M_grant or M_din to any output.
- States: IDLE, REQ, RD, RDW, WR, DONE.
- IDLE:
  - start=1 with len!=0: latch src, dst, len; clear word index i; go to REQ.
  - start=1 with len=0: go to DONE. M_req is never raised.
- REQ: M_req=1. Stay until M_grant=1 is sampled, then go to RD.
- M_req behaviour: stays 1 continuously in REQ, RD, RDW and WR. Goes to 0 in DONE and IDLE.
- RD:
  - Drives M_wr=0 and M_addr=src+i, modulo 2^ADDR_W (wraps 0xFF to 0x00).
  - Advances to RDW only if M_grant=1 this cycle; otherwise holds, address stable.
- RDW:
  - A latency counter counts RD_LAT cycles, with M_wr=0.
  - On the final count, M_din is captured into the data buffer and the FSM goes to WR.
  - The capture happens regardless of M_grant.
- WR:
  - Drives M_wr=1, M_addr=dst+i (modulo 2^ADDR_W), M_dout=buffer.
  - The write counts only on an edge where M_grant=1; otherwise the FSM holds with all outputs stable.
  - After a counted write: if i==len-1, go to DONE; otherwise increment i and go to RD.
- DONE: done=1 for exactly one cycle, busy=0, M_req=0, M_wr=0; then IDLE.
- Throughput with grant held high: 2+RD_LAT cycles per word. The REQ-to-first-RD latency is one cycle after grant.
- Grant dropped mid-transfer: the FSM stalls in RD or WR. No word is skipped or duplicated, and the buffer is preserved.
- start while busy is ignored; latched parameters do not change.
- reset_n asserted mid-transfer: immediate return to reset values. The partial copy is abandoned and no done pulse is produced.
- M_addr and M_dout hold their last values when not in RD/WR. Checkers must qualify them with the state implied by M_req/M_wr.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..DONE);
  - ADDR_W and DATA_W defaults;
  - slave window bases: RAM 0x00–0x1F, ALU 0x20 upward.
- No sub-module: the FSM, index counter, latency counter and data buffer fit in one module.

Test Plan:
- Reset: hold reset_n=0 with start=1 and M_grant=1 -> all outputs 0, state IDLE; after release, nothing happens until a new start.
- Basic copy: src=0x00, dst=0x10, len=3, RAM preloaded 0xA1,0xB2,0xC3, grant immediate, RD_LAT=1 -> read addresses 0x00,0x01,0x02; writes 0x10=0xA1, 0x11=0xB2, 0x12=0xC3; done exactly once, 9 cycles after first grant.
- Zero length: start with len=0 -> done pulses the next cycle; M_req stays 0 throughout; busy never 1.
- Grant stall: grant delayed 4 cycles after M_req, then dropped for 3 cycles during the second WR -> M_addr/M_wr/M_dout held stable; destination contents correct; no duplicate writes.
- Address wrap: src=0xFE, dst=0x1E, len=3 -> read addresses 0xFE,0xFF,0x00; write addresses 0x1E,0x1F,0x20 (the last write lands in the ALU window).
- Mid-operation events: start pulsed while busy -> ignored. reset_n low during word 1 -> outputs 0 at once, no done pulse. A fresh start then completes normally.
